// File: rtl/l2_instruction_responder.sv
// rtl/l2_instruction_responder.sv - L2 stand-in answering I-cache line misses from a word-writable store
//
// Ports:
//   clk, rst_n                               clock, synchronous active-low reset
//   address_to_l2_valid/ready_instruction_cache, address_to_l2_instruction_cache
//                                            block-address request handshake
//   data_from_l2_valid/ready_instruction_cache, data_from_l2_instruction_cache
//                                            line response handshake (word 0 in the MSBs)
//   l2_address_error                         response came from an out-of-range block
//   word_write_enable/address/data           backdoor word preload (word index, not byte)
module l2_instruction_responder #(
  parameter int ADDRESS_WIDTH       = 32,
  parameter int WORD_SIZE           = 4,
  parameter int WORD_PER_BLOCK      = 16,
  parameter int L2_DEPTH_BLOCKS     = 4,
  parameter int BLOCK_ADDRESS_WIDTH = 26,
  parameter int READ_LATENCY        = 2,
  localparam int WORD_WIDTH         = 8 * WORD_SIZE,
  localparam int BLOCK_WIDTH        = WORD_WIDTH * WORD_PER_BLOCK
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           address_to_l2_valid_instruction_cache,
  output logic                           address_to_l2_ready_instruction_cache,
  input  logic [BLOCK_ADDRESS_WIDTH-1:0] address_to_l2_instruction_cache,
  output logic                           data_from_l2_valid_instruction_cache,
  input  logic                           data_from_l2_ready_instruction_cache,
  output logic [BLOCK_WIDTH-1:0]         data_from_l2_instruction_cache,
  output logic                           l2_address_error,
  input  logic                           word_write_enable,
  input  logic [ADDRESS_WIDTH-1:0]       word_write_address,
  input  logic [WORD_WIDTH-1:0]          word_write_data
);

  localparam int DEPTH_WORDS = L2_DEPTH_BLOCKS * WORD_PER_BLOCK;
  localparam int WIDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int BIDX_W      = (L2_DEPTH_BLOCKS > 1) ? $clog2(L2_DEPTH_BLOCKS) : 1;
  localparam int CNT_W       = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [BLOCK_ADDRESS_WIDTH-1:0] DEPTH_BLK   = BLOCK_ADDRESS_WIDTH'(L2_DEPTH_BLOCKS);
  localparam logic [ADDRESS_WIDTH-1:0]       DEPTH_WRD   = ADDRESS_WIDTH'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0]               CNT_RELOAD  = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  state_t                         state;
  logic [CNT_W-1:0]               cnt;
  logic [BLOCK_ADDRESS_WIDTH-1:0] addr_q;
  logic [WORD_WIDTH-1:0]          mem [0:DEPTH_WORDS-1];
  logic [BLOCK_WIDTH-1:0]         line_rd;
  logic [BIDX_W-1:0]              blk_idx;
  logic                           addr_in_range;

  // Ready is a pure decode of the state, gated by reset so it reads 0 while
  // reset is held and 1 in the very first cycle after release.
  assign address_to_l2_ready_instruction_cache = rst_n && (state == ST_IDLE);

  // Full-width compare: high address bits never alias onto a valid block.
  assign addr_in_range = (addr_q < DEPTH_BLK);
  assign blk_idx       = addr_q[BIDX_W-1:0];

  // Assemble the requested line straight from the store; word 0 lands in the MSBs.
  always_comb begin
    line_rd = '0;
    for (int j = 0; j < WORD_PER_BLOCK; j++) begin
      line_rd[BLOCK_WIDTH-1-WORD_WIDTH*j -: WORD_WIDTH] =
        mem[WIDX_W'(int'(blk_idx) * WORD_PER_BLOCK + j)];
    end
  end

  // Backdoor store. Not reset, so preloaded contents survive a reset. The
  // line load samples mem through line_rd before this edge's write lands,
  // giving read-before-write when both happen on the same edge.
  always_ff @(posedge clk) begin
    if (word_write_enable && (word_write_address < DEPTH_WRD)) begin
      mem[WIDX_W'(word_write_address)] <= word_write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                                <= ST_IDLE;
      cnt                                  <= '0;
      addr_q                               <= '0;
      data_from_l2_valid_instruction_cache <= 1'b0;
      data_from_l2_instruction_cache       <= '0;
      l2_address_error                     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (address_to_l2_valid_instruction_cache) begin
            addr_q <= address_to_l2_instruction_cache;
            cnt    <= CNT_RELOAD;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            data_from_l2_valid_instruction_cache <= 1'b1;
            if (addr_in_range) begin
              data_from_l2_instruction_cache <= line_rd;
              l2_address_error               <= 1'b0;
            end else begin
              data_from_l2_instruction_cache <= '0;
              l2_address_error               <= 1'b1;
            end
            state <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          // Line is held stable until the consumer takes it; no new request
          // is accepted on the completion edge itself.
          if (data_from_l2_ready_instruction_cache) begin
            data_from_l2_valid_instruction_cache <= 1'b0;
            data_from_l2_instruction_cache       <= '0;
            l2_address_error                     <= 1'b0;
            state                                <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_instruction_responder.sv
// tb/tb_l2_instruction_responder.sv - scoreboard bench for l2_instruction_responder
module tb_l2_instruction_responder;

  localparam int BW = 512;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          err;
  } resp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n_v;
  logic        av;
  logic [25:0] addr;
  logic        dr;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

  logic          ar  [3];
  logic          dv  [3];
  logic          err [3];
  logic [BW-1:0] dat [3];

  l2_instruction_responder #(.READ_LATENCY(2)) u_dut_rl2 (
    .clk(clk), .rst_n(rst_n_v[0]),
    .address_to_l2_valid_instruction_cache(av),
    .address_to_l2_ready_instruction_cache(ar[0]),
    .address_to_l2_instruction_cache(addr),
    .data_from_l2_valid_instruction_cache(dv[0]),
    .data_from_l2_ready_instruction_cache(dr),
    .data_from_l2_instruction_cache(dat[0]),
    .l2_address_error(err[0]),
    .word_write_enable(we), .word_write_address(waddr), .word_write_data(wdata)
  );

  l2_instruction_responder #(.READ_LATENCY(1)) u_dut_rl1 (
    .clk(clk), .rst_n(rst_n_v[1]),
    .address_to_l2_valid_instruction_cache(av),
    .address_to_l2_ready_instruction_cache(ar[1]),
    .address_to_l2_instruction_cache(addr),
    .data_from_l2_valid_instruction_cache(dv[1]),
    .data_from_l2_ready_instruction_cache(dr),
    .data_from_l2_instruction_cache(dat[1]),
    .l2_address_error(err[1]),
    .word_write_enable(we), .word_write_address(waddr), .word_write_data(wdata)
  );

  l2_instruction_responder #(.READ_LATENCY(4)) u_dut_rl4 (
    .clk(clk), .rst_n(rst_n_v[2]),
    .address_to_l2_valid_instruction_cache(av),
    .address_to_l2_ready_instruction_cache(ar[2]),
    .address_to_l2_instruction_cache(addr),
    .data_from_l2_valid_instruction_cache(dv[2]),
    .data_from_l2_ready_instruction_cache(dr),
    .data_from_l2_instruction_cache(dat[2]),
    .l2_address_error(err[2]),
    .word_write_enable(we), .word_write_address(waddr), .word_write_data(wdata)
  );

  int            act = 0;
  logic          cur_ar, cur_dv, cur_err, cur_rst_n;
  logic [BW-1:0] cur_dat;
  int            cur_rl;

  always_comb begin
    cur_ar    = ar[act];
    cur_dv    = dv[act];
    cur_err   = err[act];
    cur_dat   = dat[act];
    cur_rst_n = rst_n_v[act];
    case (act)
      1:       cur_rl = 1;
      2:       cur_rl = 4;
      default: cur_rl = 2;
    endcase
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] model_mem [0:63];
  resp_t       exp_q [$];
  string       tag_q [$];

  function automatic logic [BW-1:0] model_line(input int b);
    logic [BW-1:0] l;
    l = '0;
    if (b < 4) begin
      for (int j = 0; j < 16; j++) l[BW-1-32*j -: 32] = model_mem[b*16+j];
    end
    return l;
  endfunction

  function automatic resp_t mk(input int b);
    resp_t r;
    r.data = model_line(b);
    r.err  = (b >= 4);
    return r;
  endfunction

  int   cyc      = 0;
  int   acc_edge = 0;
  int   last_hs  = -1;
  int   n_acc    = 0;
  bit   gap_en   = 1'b0;
  logic dv_prev  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    resp_t e;
    string t;
    if (cur_rst_n) begin
      if (av && cur_ar) begin
        acc_edge = cyc + 1;
        n_acc++;
        if (gap_en && last_hs >= 0) check("accept_gap", 576'(acc_edge - last_hs), 576'(1));
      end
      if (cur_dv && !dv_prev) check("latency", 576'(cyc - acc_edge), 576'(cur_rl));
      if (!cur_dv) check("idle_zero", 576'({cur_err, cur_dat}), 576'(0));
      if (cur_dv && dr) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 576'(1), 576'(0));
        end else begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          check({t, "_data"}, 576'(cur_dat), 576'(e.data));
          check({t, "_err"}, 576'(cur_err), 576'(e.err));
        end
        last_hs = cyc + 1;
      end
    end
    dv_prev = cur_dv;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wword(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
    if (a < 64) model_mem[a[5:0]] = d;
  endtask

  task automatic send_req(input logic [25:0] blk, input resp_t e, input string tag,
                          input bit keep, input bit push);
    int n;
    av = 1'b1; addr = blk;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (cur_ar) break;
    end
    if (n == 100) check({tag, "_accept_timeout"}, 576'(0), 576'(1));
    else if (push) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
    tick();
    if (!keep) av = 1'b0;
  endtask

  task automatic wait_resp();
    int n;
    for (n = 0; n < 200; n++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("resp_pending", 576'(exp_q.size()), 576'(0));
    exp_q.delete();
    tag_q.delete();
    tick();
  endtask

  initial begin : watchdog
    #300000;
    check("watchdog_expired", 576'(1), 576'(0));
    $fatal(1, "watchdog");
  end

  initial begin : stim
    resp_t e;
    int    n;
    int    n0;
    rst_n_v = 3'b000; av = 1'b0; addr = '0; dr = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0;
    tick(); tick();
    check("reset_ready_low", 576'(ar[0]), 576'(0));
    check("reset_valid_low", 576'(dv[0]), 576'(0));
    rst_n_v = 3'b001;
    @(negedge clk);
    check("post_reset_ready", 576'(ar[0]), 576'(1));
    check("post_reset_out", 576'({dv[0], err[0], dat[0]}), 576'(0));
    tick();

    for (int i = 0; i < 64; i++) wword(32'(i), 32'h100 + 32'(i));

    // Basic read of block 1
    dr = 1'b1;
    send_req(26'd1, mk(1), "t1_blk1", 1'b0, 1'b1);
    wait_resp();

    // Back-pressure: line held, no second accept
    dr = 1'b0;
    send_req(26'd0, mk(0), "t2_blk0", 1'b0, 1'b1);
    av = 1'b1; addr = 26'd2;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (cur_dv) break;
    end
    check("t2_valid_seen", 576'(cur_dv), 576'(1));
    n0 = n_acc;
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", 576'(cur_dv), 576'(1));
      check("t2_hold_data", 576'(cur_dat), 576'(model_line(0)));
      check("t2_ready_low", 576'(cur_ar), 576'(0));
      @(negedge clk);
    end
    check("t2_no_accept", 576'(n_acc), 576'(n0));
    @(posedge clk); #1;
    dr = 1'b1; av = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t2_valid_drop", 576'(cur_dv), 576'(0));
    check("t2_ready_back", 576'(cur_ar), 576'(1));
    wait_resp();

    // Out-of-range block
    e.data = '0; e.err = 1'b1;
    send_req(26'd4, e, "t3_blk4", 1'b0, 1'b1);
    wait_resp();

    // Reset during WAIT drops the transaction
    send_req(26'd1, mk(1), "t4_aborted", 1'b0, 1'b0);
    rst_n_v[0] = 1'b0;
    tick();
    rst_n_v[0] = 1'b1;
    @(negedge clk);
    check("t4_valid_after_rst", 576'(cur_dv), 576'(0));
    check("t4_data_after_rst", 576'(cur_dat), 576'(0));
    check("t4_ready_after_rst", 576'(cur_ar), 576'(1));
    tick();
    send_req(26'd2, mk(2), "t4_blk2", 1'b0, 1'b1);
    wait_resp();

    // Write one edge before the load edge is visible
    e = mk(1);
    e.data[479:448] = 32'hDEADBEEF;
    send_req(26'd1, e, "t5_pre_load", 1'b0, 1'b1);
    we = 1'b1; waddr = 32'd17; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0; model_mem[17] = 32'hDEADBEEF;
    wait_resp();

    // Write on the load edge is not visible (read-before-write)
    wword(32'd17, 32'h111);
    send_req(26'd1, mk(1), "t5_on_load", 1'b0, 1'b1);
    tick();
    we = 1'b1; waddr = 32'd17; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0; model_mem[17] = 32'hDEADBEEF;
    wait_resp();
    send_req(26'd1, mk(1), "t5_after", 1'b0, 1'b1);
    wait_resp();

    // Out-of-range writes ignored; high address bits do not alias
    wword(32'd64, 32'hBAD0BAD0);
    wword(32'h4000_0003, 32'hBAD1BAD1);
    send_req(26'd0, mk(0), "oob_write", 1'b0, 1'b1);
    wait_resp();
    e.data = '0; e.err = 1'b1;
    send_req(26'h200_0001, e, "no_alias", 1'b0, 1'b1);
    wait_resp();

    // Back-to-back requests with valid held, across latencies 2, 1, 4
    for (int a = 0; a < 3; a++) begin
      rst_n_v = 3'b000;
      tick(); tick();
      act = a;
      rst_n_v = 3'(1 << a);
      dr = 1'b1;
      last_hs = -1;
      gap_en = 1'b1;
      tick();
      send_req(26'd0, mk(0), $sformatf("t6_rl%0d_first", cur_rl), 1'b1, 1'b1);
      send_req(26'd3, mk(3), $sformatf("t6_rl%0d_second", cur_rl), 1'b0, 1'b1);
      wait_resp();
      gap_en = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
